// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared encodings, fixed 3x3 kernels and arithmetic helpers for the KxK conv engine
package conv_pkg;

   typedef enum logic [1:0] {
      MODE_SOBV = 2'd0,
      MODE_SOBH = 2'd1,
      MODE_LAP  = 2'd2,
      MODE_PROG = 2'd3
   } mode_e;

   // Row-major 3x3 kernels, 4-bit two's complement, element 0 is (0,0)
   localparam logic [0:8][3:0] KERN_SOBV = {4'hF, 4'hE, 4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h1};
   localparam logic [0:8][3:0] KERN_SOBH = {4'hF, 4'h0, 4'h1, 4'hE, 4'h0, 4'h2, 4'hF, 4'h0, 4'h1};
   localparam logic [0:8][3:0] KERN_LAP  = {4'h0, 4'h1, 4'h0, 4'h1, 4'hC, 4'h1, 4'h0, 4'h1, 4'h0};

   function automatic int acc_w(input int data_w, input int coef_w, input int k);
      return data_w + coef_w + $clog2(k * k) + 1;
   endfunction

   function automatic logic signed [3:0] fixed_coef(input logic [1:0] mode, input logic [3:0] idx);
      logic signed [3:0] c;
      case (mode)
         MODE_SOBV: c = KERN_SOBV[idx];
         MODE_SOBH: c = KERN_SOBH[idx];
         MODE_LAP:  c = KERN_LAP[idx];
         default:   c = 4'sd0;
      endcase
      return c;
   endfunction

   // Negative sums clamp to zero or fold to magnitude, then clip to the output range
   function automatic logic [63:0] sat(input logic signed [63:0] s, input int data_w, input bit abs_mode);
      logic signed [63:0] v;
      logic signed [63:0] maxv;
      maxv = (64'sd1 <<< data_w) - 64'sd1;
      v = s;
      if (v < 64'sd0) v = abs_mode ? -v : 64'sd0;
      if (v > maxv) v = maxv;
      return v;
   endfunction

endpackage

// File: rtl/conv_coef_bank.sv
// rtl/conv_coef_bank.sv - fixed kernel ROM plus programmable KxK coefficient file, read at the flipped index
module conv_coef_bank
   import conv_pkg::*;
#(
   parameter int K      = 3,
   parameter int COEF_W = 4,
   parameter int IDX_W  = 2,
   parameter int CA_W   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic [CA_W-1:0]          waddr,
   input  logic signed [COEF_W-1:0] wdata,
   input  logic [1:0]               mode,
   input  logic [IDX_W-1:0]         row,
   input  logic [IDX_W-1:0]         col,
   output logic signed [COEF_W-1:0] coef
);

   logic signed [COEF_W-1:0] bank [K*K];
   int ri;
   int ci;
   int idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < K * K; i++) bank[i] <= '0;
      end else if (we && (int'(waddr) < K * K)) begin
         bank[waddr] <= wdata;
      end
   end

   // True convolution: pixel (r,c) meets coefficient (K-1-r, K-1-c)
   always_comb begin
      coef = '0;
      ri   = K - 1 - int'(row);
      ci   = K - 1 - int'(col);
      idx  = ri * K + ci;
      if (ri >= 0 && ci >= 0) begin
         if (K == 3 && mode != MODE_PROG) coef = COEF_W'(fixed_coef(mode, 4'(idx)));
         else                             coef = bank[CA_W'(idx)];
      end
   end

endmodule

// File: rtl/conv_kxk_engine.sv
// rtl/conv_kxk_engine.sv - KxK convolution engine: any-order pixel arrival, MAC on arrival, saturated result
module conv_kxk_engine
   import conv_pkg::*;
#(
   parameter int K        = 3,
   parameter int DATA_W   = 8,
   parameter int COEF_W   = 4,
   parameter int ABS_MODE = 0,
   localparam int IDX_W   = $clog2(K),
   localparam int CA_W    = $clog2(K * K)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              data_in,
   input  logic [DATA_W-1:0] data,
   input  logic [IDX_W-1:0]  row_in,
   input  logic [IDX_W-1:0]  col_in,
   input  logic [1:0]        mode,
   input  logic              coef_we,
   input  logic [CA_W-1:0]   coef_addr,
   input  logic [COEF_W-1:0] coef_data,
   output logic [DATA_W-1:0] out,
   output logic              out_valid,
   output logic              busy,
   output logic              err_dup,
   output logic              err_range,
   output logic              err_coef
);

   localparam int NPIX  = K * K;
   localparam int ACC_W = acc_w(DATA_W, COEF_W, K);

   logic [NPIX-1:0]          mask;
   logic signed [ACC_W-1:0]  acc;
   mode_e                    mode_q;

   logic                     in_range;
   int                       pix_idx;
   logic [NPIX-1:0]          pix_bit;
   logic                     dup;
   logic                     accept;
   logic                     complete;
   logic [1:0]               eff_mode;
   logic signed [COEF_W-1:0] coef;
   logic signed [ACC_W-1:0]  prod;
   logic signed [ACC_W-1:0]  sum;

   assign busy = |mask;

   always_comb begin
      in_range = (int'(row_in) < K) && (int'(col_in) < K);
      pix_idx  = int'(row_in) * K + int'(col_in);
      pix_bit  = in_range ? (NPIX'(1) << pix_idx) : '0;
      dup      = data_in && in_range && |(mask & pix_bit);
      accept   = data_in && in_range && !(|(mask & pix_bit));
      complete = accept && ((mask | pix_bit) == {NPIX{1'b1}});
      // The first pixel of a window sees the incoming mode; later ones the latched mode
      eff_mode = busy ? mode_q : mode;
      prod     = ACC_W'(coef) * ACC_W'($signed({1'b0, data}));
      sum      = acc + prod;
   end

   conv_coef_bank #(
      .K      (K),
      .COEF_W (COEF_W),
      .IDX_W  (IDX_W),
      .CA_W   (CA_W)
   ) u_bank (
      .clk   (clk),
      .reset (reset),
      .we    (coef_we && !busy),
      .waddr (coef_addr),
      .wdata ($signed(coef_data)),
      .mode  (eff_mode),
      .row   (row_in),
      .col   (col_in),
      .coef  (coef)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         acc       <= '0;
         mask      <= '0;
         mode_q    <= MODE_SOBV;
         out       <= '0;
         out_valid <= 1'b0;
         err_dup   <= 1'b0;
         err_range <= 1'b0;
         err_coef  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         err_range <= data_in && !in_range;
         err_dup   <= dup;
         err_coef  <= coef_we && busy;
         if (accept) begin
            if (!busy) mode_q <= mode_e'(mode);
            if (complete) begin
               acc       <= '0;
               mask      <= '0;
               out       <= DATA_W'(sat(64'(sum), DATA_W, ABS_MODE != 0));
               out_valid <= 1'b1;
            end else begin
               acc  <= sum;
               mask <= mask | pix_bit;
            end
         end
      end
   end

endmodule
